// File: rtl/vedic_pkg.sv
// Shared types and constants for the Vedic MAC accumulator slice.
// Holds the product width, the controller state encoding and the parameter legality check.
package vedic_pkg;

   localparam int PROD_W = 8;
   localparam int CNT_W  = 8;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } acc_state_t;

   // Legal configurations: accumulator at least as wide as one product, 1..255 terms.
   function automatic bit params_ok(input int acc_w, input int n_terms);
      return (acc_w >= PROD_W) && (n_terms >= 1) && (n_terms <= 255);
   endfunction

endpackage

// File: rtl/vedic_acc_ctrl.sv
// Group controller for the MAC accumulator: ACCUM/HOLD state machine and term counter.
// Produces the handshake outputs and the datapath strobes.
module vedic_acc_ctrl
   import vedic_pkg::*;
#(
   parameter int N_TERMS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   input  logic             out_ready,
   output logic             in_ready,
   output logic             out_valid,
   output logic             accept,
   output logic             first_term,
   output logic             last_term,
   output logic             load_result,
   output logic [CNT_W-1:0] term_cnt
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TERMS - 1);

   acc_state_t       state_reg, state_next;
   logic [CNT_W-1:0] term_cnt_reg, term_cnt_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ACCUM;
         term_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         term_cnt_reg <= term_cnt_next;
      end
   end

   always_comb begin
      in_ready      = 1'b0;
      out_valid     = (state_reg == HOLD);
      state_next    = state_reg;
      term_cnt_next = term_cnt_reg;

      // A cycle that clr discards must not look like an accepted transfer upstream.
      if (!rst && !clr) begin
         in_ready = (state_reg == ACCUM) || out_ready;
      end

      accept      = in_valid && in_ready;
      first_term  = (term_cnt_reg == '0);
      last_term   = (term_cnt_reg == LAST_IDX);
      load_result = accept && last_term;

      // In HOLD, term_cnt is 0, so a simultaneous input becomes term 1 of the next group.
      if (clr) begin
         state_next    = ACCUM;
         term_cnt_next = '0;
      end else if (load_result) begin
         state_next    = HOLD;
         term_cnt_next = '0;
      end else if (accept) begin
         state_next    = ACCUM;
         term_cnt_next = term_cnt_reg + 1'b1;
      end else if (out_valid && out_ready) begin
         state_next    = ACCUM;
      end
   end

   assign term_cnt = term_cnt_reg;

endmodule

// File: rtl/vedic_mac_accumulator.sv
// Sums N_TERMS unsigned 8-bit products per group and presents each sum with a sticky
// overflow flag on a held valid/ready output.
module vedic_mac_accumulator
   import vedic_pkg::*;
#(
   parameter int N_TERMS = 4,
   parameter int ACC_W   = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [PROD_W-1:0] prod,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ACC_W-1:0]  result,
   output logic              ovf,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  term_cnt
);

   generate
      if (!params_ok(ACC_W, N_TERMS)) begin : g_param_check
         $error("vedic_mac_accumulator: illegal ACC_W=%0d / N_TERMS=%0d", ACC_W, N_TERMS);
      end
   endgenerate

   logic accept, first_term, last_term, load_result;

   vedic_acc_ctrl #(
      .N_TERMS (N_TERMS)
   ) u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr),
      .in_valid    (in_valid),
      .out_ready   (out_ready),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .accept      (accept),
      .first_term  (first_term),
      .last_term   (last_term),
      .load_result (load_result),
      .term_cnt    (term_cnt)
   );

   logic [ACC_W:0]   sum_wide;
   logic [ACC_W-1:0] acc_reg, acc_next, result_reg;
   logic             run_ovf_reg, run_ovf_next, ovf_reg;

   always_comb begin
      sum_wide = {1'b0, acc_reg} + (ACC_W+1)'(prod);
      if (first_term) begin
         acc_next     = ACC_W'(prod);
         run_ovf_next = 1'b0;
      end else begin
         acc_next     = sum_wide[ACC_W-1:0];
         run_ovf_next = run_ovf_reg | sum_wide[ACC_W];
      end
   end

   // The running sum self-clears once the group is handed to the result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg     <= '0;
         run_ovf_reg <= 1'b0;
         result_reg  <= '0;
         ovf_reg     <= 1'b0;
      end else if (clr) begin
         acc_reg     <= '0;
         run_ovf_reg <= 1'b0;
      end else begin
         if (accept) begin
            acc_reg     <= last_term ? '0 : acc_next;
            run_ovf_reg <= last_term ? 1'b0 : run_ovf_next;
         end
         if (load_result) begin
            result_reg <= acc_next;
            ovf_reg    <= run_ovf_next;
         end
      end
   end

   assign result = result_reg;
   assign ovf    = ovf_reg;

endmodule
